// File: rtl/dsm_pkg.sv
// dsm_pkg: shared constants and state encoding for the delta-sigma
// modulator sequencer (dsm_seq) and its helpers.
//   DSM_DW    : default alpha / sample word width
//   DSM_OW    : default oversampling-ratio field width
//   FLUSH_CYC : number of cycles the modulator is held in reset before a run
//   dsm_state_e / ST_* : sequencer state encoding
package dsm_pkg;

    localparam int DSM_DW    = 16;
    localparam int DSM_OW    = 8;
    localparam int FLUSH_CYC = 3;

    // Encoding kept as plain vectors so the sequencer can use them as
    // legacy-style localparam state constants.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_FLUSH = ST_FLUSH,
        S_LOAD  = ST_LOAD,
        S_RUN   = ST_RUN
    } dsm_state_e;

endpackage

// File: rtl/dsm_seq_if.sv
// dsm_seq_if: sample stream handshake feeding the sequencer.
//   s_valid : source has a sample on s_data
//   s_data  : sample word (DW bits)
//   s_ready : sequencer accepts the sample on this edge
// Modports: master = sample source, slave = dsm_seq.
interface dsm_seq_if
    import dsm_pkg::*;
#(
    parameter int DW = DSM_DW
) ();

    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/dsm_ones_counter.sv
// dsm_ones_counter: counts cycles with msb=1 while enabled.
//   clk, reset : clock and synchronous active-high reset
//   clear      : zero the count on the next edge (has priority over enable)
//   enable     : accumulate msb on the next edge
//   msb        : modulator bitstream bit
//   count      : running number of ones since the last clear
module dsm_ones_counter #(
    parameter int CW = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    input  logic          msb,
    output logic [CW-1:0] count
);

    // Per-frame ones accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= {CW{1'b0}};
        end else if (clear) begin
            count <= {CW{1'b0}};
        end else if (enable) begin
            count <= count + {{(CW-1){1'b0}}, msb};
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/dsm_seq.sv
// dsm_seq: sequences sample words into a delta-sigma modulator.
// A run starts with a flush (modulator held in reset), then each accepted
// sample is presented on alpha for osr cycles (one frame) while the number
// of ones in the modulator bitstream is counted.
//   clk, reset  : clock, synchronous active-high reset
//   start, stop : run control levels
//   osr         : samples-per-frame, captured on an accepted start (0 -> 1)
//   s_if        : sample stream (slave side)
//   alpha       : registered modulator input word
//   dsm_reset   : registered modulator reset
//   msb         : modulator bitstream
//   busy        : run in progress
//   underrun    : sticky, LOAD starved after at least one frame
//   frame_done  : one-cycle pulse after the last cycle of each frame
//   frame_ones  : ones counted in the most recent frame
module dsm_seq
    import dsm_pkg::*;
#(
    parameter int DW = DSM_DW,
    parameter int OW = DSM_OW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic [OW-1:0] osr,
    dsm_seq_if.slave      s_if,
    output logic [DW-1:0] alpha,
    output logic          dsm_reset,
    input  logic          msb,
    output logic          busy,
    output logic          underrun,
    output logic          frame_done,
    output logic [OW:0]   frame_ones
);

    localparam logic [OW-1:0] ONE_OW     = {{(OW-1){1'b0}}, 1'b1};
    localparam logic [1:0]    FLUSH_LAST = 2'(FLUSH_CYC - 1);

    logic [1:0]    state_r;
    logic [1:0]    state_nx_s;
    logic [1:0]    flush_cnt_r;
    logic [OW-1:0] cnt_r;
    logic [OW-1:0] osr_q_r;
    logic          stop_seen_r;
    logic          frame_seen_r;
    logic          start_ok_s;
    logic          stop_eff_s;
    logic          last_s;
    logic          ready_s;
    logic          xfer_s;
    logic [OW:0]   ones_count_s;

    // stop is remembered through FLUSH and RUN so a short stop level still
    // ends the run at the next boundary.
    assign start_ok_s = (state_r == ST_IDLE) && start && !stop;
    assign stop_eff_s = stop | stop_seen_r;
    assign last_s     = (state_r == ST_RUN) && (cnt_r == (osr_q_r - ONE_OW));
    assign xfer_s     = s_if.s_valid & ready_s;
    assign s_if.s_ready = ready_s;

    // Ready only where a new sample can be taken; stop blocks any transfer.
    always_comb begin
        ready_s = 1'b0;
        if (stop_eff_s) begin
            ready_s = 1'b0;
        end else if (state_r == ST_LOAD) begin
            ready_s = 1'b1;
        end else if (last_s) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) state_nx_s = ST_FLUSH;
                else            state_nx_s = ST_IDLE;
            end
            ST_FLUSH: begin
                if (flush_cnt_r == FLUSH_LAST) begin
                    if (stop_eff_s) state_nx_s = ST_IDLE;
                    else            state_nx_s = ST_LOAD;
                end else begin
                    state_nx_s = ST_FLUSH;
                end
            end
            ST_LOAD: begin
                if (stop)        state_nx_s = ST_IDLE;
                else if (xfer_s) state_nx_s = ST_RUN;
                else             state_nx_s = ST_LOAD;
            end
            ST_RUN: begin
                if (last_s) begin
                    if (stop_eff_s)  state_nx_s = ST_IDLE;
                    else if (xfer_s) state_nx_s = ST_RUN;
                    else             state_nx_s = ST_LOAD;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // The frame total includes the msb of the last RUN cycle, which the
    // counter only sees on the same edge it is cleared.
    dsm_ones_counter #(.CW(OW + 1)) u_ones (
        .clk    (clk),
        .reset  (reset),
        .clear  (last_s),
        .enable (state_r == ST_RUN),
        .msb    (msb),
        .count  (ones_count_s)
    );

    // Sequencer registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            flush_cnt_r  <= 2'd0;
            cnt_r        <= {OW{1'b0}};
            osr_q_r      <= ONE_OW;
            stop_seen_r  <= 1'b0;
            frame_seen_r <= 1'b0;
            alpha        <= {DW{1'b0}};
            dsm_reset    <= 1'b1;
            busy         <= 1'b0;
            underrun     <= 1'b0;
            frame_done   <= 1'b0;
            frame_ones   <= {(OW + 1){1'b0}};
        end else begin
            state_r   <= state_nx_s;
            busy      <= (state_nx_s != ST_IDLE);
            dsm_reset <= (state_nx_s == ST_IDLE) || (state_nx_s == ST_FLUSH);

            if (start_ok_s) begin
                osr_q_r <= (osr == {OW{1'b0}}) ? ONE_OW : osr;
            end else begin
                osr_q_r <= osr_q_r;
            end

            if (state_r == ST_FLUSH) flush_cnt_r <= flush_cnt_r + 2'd1;
            else                     flush_cnt_r <= 2'd0;

            if (state_nx_s == ST_IDLE) begin
                stop_seen_r <= 1'b0;
            end else if (((state_r == ST_FLUSH) || (state_r == ST_RUN)) && stop) begin
                stop_seen_r <= 1'b1;
            end else begin
                stop_seen_r <= stop_seen_r;
            end

            if (state_nx_s == ST_RUN) cnt_r <= xfer_s ? {OW{1'b0}} : (cnt_r + ONE_OW);
            else                      cnt_r <= {OW{1'b0}};

            if (state_nx_s == ST_IDLE) alpha <= {DW{1'b0}};
            else if (xfer_s)           alpha <= s_if.s_data;
            else                       alpha <= alpha;

            if (start_ok_s)  frame_seen_r <= 1'b0;
            else if (last_s) frame_seen_r <= 1'b1;
            else             frame_seen_r <= frame_seen_r;

            // Starved LOAD only counts once a frame has completed in this run.
            if (start_ok_s) begin
                underrun <= 1'b0;
            end else if ((state_r == ST_LOAD) && !stop && !s_if.s_valid && frame_seen_r) begin
                underrun <= 1'b1;
            end else begin
                underrun <= underrun;
            end

            frame_done <= last_s;
            if (last_s) frame_ones <= ones_count_s + {{OW{1'b0}}, msb};
            else        frame_ones <= frame_ones;
        end
    end

endmodule

// File: tb/tb_dsm_seq.sv
// tb_dsm_seq: self-checking bench for dsm_seq. Expected behaviour is
// computed per scenario from the run timeline: a start at edge 0 gives
// flush at observations 0..2, LOAD at 3, and frame k of n cycles at
// observations 4+k*n .. 3+(k+1)*n.
module tb_dsm_seq;
    import dsm_pkg::*;

    localparam int DW = 16;
    localparam int OW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          stop;
    logic          msb;
    logic [OW-1:0] osr;
    logic [DW-1:0] alpha;
    logic          dsm_reset;
    logic          busy;
    logic          underrun;
    logic          frame_done;
    logic [OW:0]   frame_ones;
    int            checks   = 0;
    int            failures = 0;

    dsm_seq_if #(.DW(DW)) sif ();

    dsm_seq #(.DW(DW), .OW(OW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .osr        (osr),
        .s_if       (sif.slave),
        .alpha      (alpha),
        .dsm_reset  (dsm_reset),
        .msb        (msb),
        .busy       (busy),
        .underrun   (underrun),
        .frame_done (frame_done),
        .frame_ones (frame_ones)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [29:0] got;
        logic [29:0] exp;
        exp = {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000};
        reset = 1'b1; start = 1'b1; stop = 1'b0; osr = 8'd5;
        sif.s_valid = 1'b1; sif.s_data = 16'h1234; msb = 1'b1;
        step(); step(); step();
        got = {alpha, dsm_reset, sif.s_ready, busy, underrun, frame_done, frame_ones};
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL reset_state got=%h exp=%h", got, exp);
        end
        start = 1'b0; reset = 1'b0;
        step(); step();
        checks++;
        if (busy !== 1'b0 || dsm_reset !== 1'b1 || alpha !== 16'h0000) begin
            failures++; $display("FAIL idle_after_reset busy=%b dsm_reset=%b alpha=%h exp 0/1/0000", busy, dsm_reset, alpha);
        end
    endtask

    // Continuous-valid run of m frames of n cycles, stopped on the last cycle.
    task automatic test_stream(input logic [OW-1:0] osr_in, input int n, input int m, input bit fixed);
        logic [DW-1:0] d [9];
        int            sum [9];
        logic [3:0]    pat;
        logic [DW-1:0] exp_alpha;
        logic          exp_busy, exp_dsr, exp_fd, exp_rdy;
        int            last_i;
        pat = 4'b1101;
        for (int k = 0; k < 9; k++) begin
            d[k] = DW'($urandom);
            sum[k] = 0;
        end
        if (fixed) begin
            d[0] = 16'h8000; d[1] = 16'h4000;
        end
        last_i = 4 + n * m;
        sif.s_valid = 1'b1; sif.s_data = DW'($urandom); stop = 1'b0; msb = 1'b0;
        osr = osr_in; start = 1'b1;
        #1;
        checks++;
        if (sif.s_ready !== 1'b0) begin
            failures++; $display("FAIL stream_idle_ready got=%b exp=0", sif.s_ready);
        end
        step();
        for (int i = 0; i <= last_i; i++) begin
            exp_busy  = (i < last_i);
            exp_dsr   = (i < 3) || (i == last_i);
            exp_alpha = ((i < 4) || (i == last_i)) ? 16'h0000 : d[(i - 4) / n];
            exp_fd    = (i > 4) && (((i - 4) % n) == 0);
            checks++;
            if (busy !== exp_busy || dsm_reset !== exp_dsr) begin
                failures++; $display("FAIL stream_busy_dsr i=%0d got=%b%b exp=%b%b", i, busy, dsm_reset, exp_busy, exp_dsr);
            end
            checks++;
            if (alpha !== exp_alpha) begin
                failures++; $display("FAIL stream_alpha i=%0d got=%h exp=%h", i, alpha, exp_alpha);
            end
            checks++;
            if (frame_done !== exp_fd) begin
                failures++; $display("FAIL stream_frame_done i=%0d got=%b exp=%b", i, frame_done, exp_fd);
            end
            if (exp_fd) begin
                checks++;
                if (frame_ones !== 9'(sum[(i - 4) / n - 1])) begin
                    failures++; $display("FAIL stream_frame_ones i=%0d got=%0d exp=%0d", i, frame_ones, sum[(i - 4) / n - 1]);
                end
            end
            if (i < last_i) begin
                start = 1'($urandom_range(0, 1));
                osr   = OW'($urandom);
                stop  = (i == last_i - 1);
                if (i < 3)       sif.s_data = DW'($urandom);
                else if (i == 3) sif.s_data = d[0];
                else             sif.s_data = d[(i - 4) / n + 1];
                msb = 1'($urandom_range(0, 1));
                if (fixed && i >= 4 && i < 8) msb = pat[i - 4];
                if (i >= 4) sum[(i - 4) / n] += int'(msb);
                exp_rdy = (i == 3) || ((i >= 4) && (((i - 4) % n) == n - 1) && !stop);
                #1;
                checks++;
                if (sif.s_ready !== exp_rdy) begin
                    failures++; $display("FAIL stream_ready i=%0d got=%b exp=%b", i, sif.s_ready, exp_rdy);
                end
                step();
            end
        end
        start = 1'b0; stop = 1'b0;
        step();
        checks++;
        if (frame_done !== 1'b0 || frame_ones !== 9'(sum[m - 1]) || busy !== 1'b0) begin
            failures++; $display("FAIL stream_hold fd=%b ones=%0d busy=%b exp 0/%0d/0", frame_done, frame_ones, busy, sum[m - 1]);
        end
    endtask

    task automatic test_underrun();
        logic [DW-1:0] d0, d1, exp_alpha;
        logic          exp_rdy, exp_ur;
        int            w;
        d0 = DW'($urandom); d1 = DW'($urandom);
        osr = 8'd2; start = 1'b1; stop = 1'b0; sif.s_valid = 1'b1; sif.s_data = d0;
        step();
        start = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            exp_alpha = (i < 4) ? 16'h0000 : ((i <= 8) ? d0 : d1);
            exp_ur    = (i >= 7);
            checks++;
            if (alpha !== exp_alpha || underrun !== exp_ur || frame_done !== (i == 6)) begin
                failures++; $display("FAIL underrun_seq i=%0d alpha=%h ur=%b fd=%b exp %h/%b/%b", i, alpha, underrun, frame_done, exp_alpha, exp_ur, (i == 6));
            end
            osr = OW'($urandom);
            msb = 1'($urandom_range(0, 1));
            sif.s_valid = !((i >= 5) && (i <= 7));
            sif.s_data  = (i >= 8) ? d1 : d0;
            stop = (i == 10);
            exp_rdy = (i == 3) || (i == 5) || (i == 6) || (i == 7) || (i == 8);
            #1;
            checks++;
            if (sif.s_ready !== exp_rdy) begin
                failures++; $display("FAIL underrun_ready i=%0d got=%b exp=%b", i, sif.s_ready, exp_rdy);
            end
            step();
        end
        w = 0;
        while (busy !== 1'b0 && w < 40) begin step(); w++; end
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL underrun_stop_wait busy=%b exp=0", busy);
        end
        step(); step();
        checks++;
        if (underrun !== 1'b1) begin
            failures++; $display("FAIL underrun_sticky got=%b exp=1", underrun);
        end
        start = 1'b1; osr = 8'd3;
        step();
        start = 1'b0;
        checks++;
        if (underrun !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL underrun_clear ur=%b busy=%b exp 0/1", underrun, busy);
        end
        stop = 1'b1;
        w = 0;
        while (busy !== 1'b0 && w < 40) begin step(); w++; end
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL underrun_final_wait busy=%b exp=0", busy);
        end
    endtask

    task automatic test_stop_mid();
        logic [DW-1:0] d0, exp_alpha;
        d0 = DW'($urandom);
        osr = 8'd8; start = 1'b1; stop = 1'b0; sif.s_valid = 1'b1; sif.s_data = d0;
        step();
        start = 1'b0;
        for (int i = 0; i <= 12; i++) begin
            exp_alpha = ((i < 4) || (i == 12)) ? 16'h0000 : d0;
            checks++;
            if (alpha !== exp_alpha || busy !== (i < 12) || dsm_reset !== ((i < 3) || (i == 12)) || frame_done !== (i == 12)) begin
                failures++; $display("FAIL stop_mid i=%0d alpha=%h busy=%b dsr=%b fd=%b exp %h/%b/%b/%b", i, alpha, busy, dsm_reset, frame_done, exp_alpha, (i < 12), ((i < 3) || (i == 12)), (i == 12));
            end
            if (i < 12) begin
                stop = (i >= 7);
                sif.s_data = (i < 4) ? d0 : DW'($urandom);
                msb = 1'($urandom_range(0, 1));
                #1;
                checks++;
                if (sif.s_ready !== (i == 3)) begin
                    failures++; $display("FAIL stop_mid_ready i=%0d got=%b exp=%b", i, sif.s_ready, (i == 3));
                end
                step();
            end
        end
        stop = 1'b0;
    endtask

    task automatic test_stop_early();
        osr = OW'($urandom_range(1, 9)); start = 1'b1; stop = 1'b0; sif.s_valid = 1'b0;
        step();
        start = 1'b0; stop = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (busy !== (i < 3) || dsm_reset !== 1'b1) begin
                failures++; $display("FAIL stop_flush i=%0d busy=%b dsr=%b exp %b/1", i, busy, dsm_reset, (i < 3));
            end
        end
        stop = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        checks++;
        if (busy !== 1'b1 || dsm_reset !== 1'b0) begin
            failures++; $display("FAIL stop_load_reach busy=%b dsr=%b exp 1/0", busy, dsm_reset);
        end
        stop = 1'b1;
        #1;
        checks++;
        if (sif.s_ready !== 1'b0) begin
            failures++; $display("FAIL stop_load_ready got=%b exp=0", sif.s_ready);
        end
        step();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || alpha !== 16'h0000 || underrun !== 1'b0) begin
            failures++; $display("FAIL stop_load busy=%b alpha=%h ur=%b exp 0/0000/0", busy, alpha, underrun);
        end
        sif.s_valid = 1'b1;
    endtask

    task automatic test_start_stop_idle();
        start = 1'b1; stop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (busy !== 1'b0 || dsm_reset !== 1'b1) begin
                failures++; $display("FAIL start_with_stop i=%0d busy=%b dsr=%b exp 0/1", i, busy, dsm_reset);
            end
        end
        start = 1'b0; stop = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d0;
        logic [29:0]   got;
        logic [29:0]   exp;
        exp = {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000};
        d0 = DW'($urandom);
        osr = 8'd4; start = 1'b1; stop = 1'b0; sif.s_valid = 1'b1; sif.s_data = d0;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            msb = 1'b1; sif.s_data = (i < 4) ? d0 : DW'($urandom);
            step();
        end
        checks++;
        if (alpha !== d0 || busy !== 1'b1) begin
            failures++; $display("FAIL reset_mid_pre alpha=%h busy=%b exp %h/1", alpha, busy, d0);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        got = {alpha, dsm_reset, sif.s_ready, busy, underrun, frame_done, frame_ones};
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL reset_mid_state got=%h exp=%h", got, exp);
        end
        step(); step();
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL reset_mid_after fd=%b busy=%b exp 0/0", frame_done, busy);
        end
    endtask

    initial begin
        int n;
        int m;
        reset = 1'b1; start = 1'b0; stop = 1'b0; msb = 1'b0; osr = 8'd0;
        sif.s_valid = 1'b0; sif.s_data = 16'h0000;
        test_reset();
        test_stream(8'd4, 4, 3, 1'b1);
        test_underrun();
        test_stop_mid();
        test_stop_early();
        test_start_stop_idle();
        test_stream(8'd0, 1, 5, 1'b0);
        for (int r = 0; r < 5; r++) begin
            n = $urandom_range(1, 7);
            m = $urandom_range(1, 8);
            test_stream(OW'(n), n, m, 1'b0);
        end
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dsm_seq.md
DSM_SEQ -- requirements
Module: dsm_seq

Interface
REQ-001 SHALL have parameter DW, default 16, meaning alpha/sample width.
REQ-002 SHALL have parameter OW, default 8, meaning oversampling-ratio field width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, level; begins a conversion run from IDLE.
REQ-006 SHALL have port stop, input, 1, level; ends the run after the current frame.
REQ-007 SHALL have port osr, input, OW, samples-per-frame count, captured on accepted start.
REQ-008 SHALL have ports s_valid (input, 1), s_data (input, DW), s_ready (output, 1): sample stream handshake.
REQ-009 SHALL have port alpha, output, DW, registered modulator input word.
REQ-010 SHALL have port dsm_reset, output, 1, registered reset to the modulator.
REQ-011 SHALL have port msb, input, 1, modulator bitstream output.
REQ-012 SHALL have ports busy (output, 1), underrun (output, 1, sticky), frame_done (output, 1, pulse), frame_ones (output, OW+1).

Function
REQ-013 SHALL implement FSM states IDLE, FLUSH, LOAD, RUN.
REQ-014 IDLE: start=1 and stop=0 -> FLUSH, capture osr (osr=0 captured as 1); start with stop=1 -> stay IDLE.
REQ-015 FLUSH: hold dsm_reset=1 for exactly FLUSH_CYC=3 cycles, then -> LOAD.
REQ-016 s_ready SHALL be 1 in LOAD and in the last RUN cycle (cnt==osr_q-1), else 0.
REQ-017 Transfer occurs when s_valid & s_ready; alpha<=s_data next edge, cnt<=0, state RUN.
REQ-018 LOAD with s_valid=0: stay LOAD, alpha unchanged; if at least one frame already completed this run, set underrun.
REQ-019 RUN: cnt increments each cycle; at cnt==osr_q-1 with no transfer and stop=0 -> LOAD; with stop=1 -> IDLE (stop wins over a pending transfer, s_ready forced 0 when stop=1).
REQ-020 stop in LOAD -> IDLE next cycle; stop in FLUSH -> IDLE after the flush completes.
REQ-021 dsm_reset SHALL be 1 in IDLE and FLUSH, 0 in LOAD and RUN; alpha SHALL be cleared to 0 on entry to IDLE.
REQ-022 SHALL count msb=1 cycles during RUN, per frame, with no latency compensation; count saturates never (max osr fits OW+1 bits).
REQ-023 frame_done SHALL pulse one cycle, in the cycle after the last RUN cycle of each frame; frame_ones updates in that same cycle and holds until the next frame_done.
REQ-024 busy SHALL be 1 whenever state != IDLE.
REQ-025 underrun SHALL clear only on reset or on an accepted start.
REQ-026 osr changes during a run SHALL have no effect until the next accepted start.

Reset
REQ-027 On reset: state IDLE, alpha=0, dsm_reset=1, s_ready=0, busy=0, underrun=0, frame_done=0, frame_ones=0, cnt=0, osr_q=1.
REQ-028 Reset asserted mid-frame SHALL abort immediately with no frame_done for the partial frame.

Structure
REQ-029 Package dsm_pkg SHALL hold the state enum, FLUSH_CYC, and default DW/OW constants.
REQ-030 One sub-module dsm_ones_counter (clear, enable, msb -> count) SHALL implement the per-frame counter; FSM and handshake stay in dsm_seq.

Verification
REQ-031 Reset then start, osr=4, continuous s_valid with 0x8000,0x4000 -> dsm_reset high 3 cycles, alpha=0x8000 for 4 cycles then 0x4000 with no bubble, frame_done every 4 cycles.
REQ-032 msb forced 1,0,1,1 over a 4-cycle frame -> frame_ones=3 with frame_done.
REQ-033 osr=2, s_valid dropped for 3 cycles after first frame -> s_ready held in LOAD, alpha held, underrun=1 and stays 1 until next start.
REQ-034 stop raised mid-frame (osr=8, cnt=3) -> frame completes, frame_done pulses, IDLE, dsm_reset=1, alpha=0, busy=0.
REQ-035 start and stop both high in IDLE -> stays IDLE; start with osr=0 -> frames of 1 cycle, frame_done every cycle.
REQ-036 reset asserted at cnt=2 of an osr=4 frame -> all outputs at reset values next cycle, no frame_done.
